// File: rtl/gcd_feeder.sv
// gcd_feeder: operand FIFO and issue controller in front of the subtractive gcd core.
// Operand pairs are queued, dispatched one at a time to the core, and each result
// is returned on a valid/ready stream tagged with the core's compute latency.
// Pairs with a zero operand never reach the core (it would not terminate); the
// feeder answers them directly with a|b and a latency tag of zero.

module gcd_feeder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // operand stream
  input  logic                       op_valid_i,
  output logic                       op_ready_o,
  input  logic [XLEN-1:0]            op_a_i,
  input  logic [XLEN-1:0]            op_b_i,
  // core interface
  output logic                       core_ld_o,
  output logic [XLEN-1:0]            core_a_o,
  output logic [XLEN-1:0]            core_b_o,
  input  logic                       core_ready_i,
  input  logic                       core_valid_i,
  input  logic [XLEN-1:0]            core_gcd_i,
  // result stream
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [XLEN-1:0]            res_gcd_o,
  output logic [CNTW-1:0]            res_cycles_o,
  output logic                       res_bypass_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0]   PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] LAT_ZERO  = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] LAT_ONE   = {{(CNTW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] LAT_MAX   = {CNTW{1'b1}};
  localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Saturating +1 for the latency counter; it must never wrap back to a small value.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    logic [CNTW-1:0] r;
    if (v == LAT_MAX) begin
      r = LAT_MAX;
    end else begin
      r = v + LAT_ONE;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_r;
  state_t            state_next_s;

  logic [XLEN-1:0]   mem_a_r [DEPTH];
  logic [XLEN-1:0]   mem_b_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic [XLEN-1:0]   core_a_r;
  logic [XLEN-1:0]   core_b_r;
  logic              core_ld_r;
  logic [CNTW-1:0]   lat_cnt_r;

  logic              res_valid_r;
  logic [XLEN-1:0]   res_gcd_r;
  logic [CNTW-1:0]   res_cycles_r;
  logic              res_bypass_r;

  // ---------------------------------------------------------------------------
  // Decoded control
  // ---------------------------------------------------------------------------
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              issue_s;
  logic              bypass_s;
  logic              capture_s;
  logic [XLEN-1:0]   head_a_s;
  logic [XLEN-1:0]   head_b_s;
  logic              head_zero_s;

  // Full/empty come from the registered count only, so ready has no path from pop.
  assign fifo_full_s  = (count_r == CNT_FULL);
  assign fifo_empty_s = (count_r == CNT_ZERO);
  assign push_s       = op_valid_i && !fifo_full_s;

  assign head_a_s     = mem_a_r[rd_ptr_r];
  assign head_b_s     = mem_b_r[rd_ptr_r];
  assign head_zero_s  = (head_a_s == DATA_ZERO) || (head_b_s == DATA_ZERO);

  // Next-state and one-cycle control strobes for the dispatch FSM.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    issue_s      = 1'b0;
    bypass_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fifo_empty_s) begin
          state_next_s = IDLE;
        end else if (head_zero_s) begin
          // Zero operand: answer locally, the core is not involved.
          pop_s        = 1'b1;
          bypass_s     = 1'b1;
          state_next_s = HOLD;
        end else if (core_ready_i) begin
          pop_s        = 1'b1;
          issue_s      = 1'b1;
          state_next_s = ISSUE;
        end else begin
          // Core busy: keep the head queued.
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
      end
      WAIT: begin
        if (core_valid_i) begin
          capture_s    = 1'b1;
          state_next_s = HOLD;
        end else begin
          state_next_s = WAIT;
        end
      end
      HOLD: begin
        if (res_ready_i) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_a_r[wr_ptr_r] <= op_a_i;
      mem_b_r[wr_ptr_r] <= op_b_i;
    end
  end

  // Core operand latches: load on dispatch, otherwise hold the last issued pair.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_a_r <= DATA_ZERO;
      core_b_r <= DATA_ZERO;
    end else if (issue_s) begin
      core_a_r <= head_a_s;
      core_b_r <= head_b_s;
    end else begin
      core_a_r <= core_a_r;
      core_b_r <= core_b_r;
    end
  end

  // Load pulse is high exactly while the FSM sits in ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_ld_r <= 1'b0;
    end else begin
      core_ld_r <= (state_next_s == ISSUE);
    end
  end

  // Latency counter: cleared on dispatch, counts WAIT cycles, saturates at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lat_cnt_r <= LAT_ZERO;
    end else if (issue_s) begin
      lat_cnt_r <= LAT_ZERO;
    end else if (state_r == WAIT) begin
      lat_cnt_r <= sat_inc(lat_cnt_r);
    end else begin
      lat_cnt_r <= lat_cnt_r;
    end
  end

  // Result registers: loaded by bypass or core capture, frozen while HOLD waits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_gcd_r    <= DATA_ZERO;
      res_cycles_r <= LAT_ZERO;
      res_bypass_r <= 1'b0;
    end else if (bypass_s) begin
      res_gcd_r    <= head_a_s | head_b_s;
      res_cycles_r <= LAT_ZERO;
      res_bypass_r <= 1'b1;
    end else if (capture_s) begin
      res_gcd_r    <= core_gcd_i;
      res_cycles_r <= sat_inc(lat_cnt_r);
      res_bypass_r <= 1'b0;
    end else begin
      res_gcd_r    <= res_gcd_r;
      res_cycles_r <= res_cycles_r;
      res_bypass_r <= res_bypass_r;
    end
  end

  // Result valid is high exactly while the FSM sits in HOLD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= (state_next_s == HOLD);
    end
  end

  assign op_ready_o   = !fifo_full_s;
  assign count_o      = count_r;
  assign core_ld_o    = core_ld_r;
  assign core_a_o     = core_a_r;
  assign core_b_o     = core_b_r;
  assign res_valid_o  = res_valid_r;
  assign res_gcd_o    = res_gcd_r;
  assign res_cycles_o = res_cycles_r;
  assign res_bypass_o = res_bypass_r;

endmodule

// File: tb/tb_gcd_feeder.sv
// tb_gcd_feeder: directed and random checks of gcd_feeder against a reference
// model of the feeder's result stream and a behavioural gcd core.

module tb_gcd_feeder;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int LMAX  = (1 << CNTW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            op_valid_i = 1'b0;
  logic            op_ready_o;
  logic [XLEN-1:0] op_a_i = '0;
  logic [XLEN-1:0] op_b_i = '0;
  logic            core_ld_o;
  logic [XLEN-1:0] core_a_o;
  logic [XLEN-1:0] core_b_o;
  logic            core_ready_i;
  logic            core_valid_i = 1'b0;
  logic [XLEN-1:0] core_gcd_i = '0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b1;
  logic [XLEN-1:0] res_gcd_o;
  logic [CNTW-1:0] res_cycles_o;
  logic            res_bypass_o;
  logic [CW-1:0]   count_o;

  gcd_feeder #(.XLEN(XLEN), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .core_ld_o    (core_ld_o),
    .core_a_o     (core_a_o),
    .core_b_o     (core_b_o),
    .core_ready_i (core_ready_i),
    .core_valid_i (core_valid_i),
    .core_gcd_i   (core_gcd_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_gcd_o    (res_gcd_o),
    .res_cycles_o (res_cycles_o),
    .res_bypass_o (res_bypass_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference gcd by Euclid; a zero operand yields the other operand.
  function automatic logic [XLEN-1:0] ref_gcd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] x, y, t;
    x = a; y = b;
    if (x == '0 || y == '0) return x | y;
    while (y != '0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  // Expected result stream, in push order.
  logic [XLEN-1:0] exp_g[$];
  int              exp_c[$];
  bit              exp_b[$];
  int              lat_q[$];

  // Behavioural core: takes its latency per job from lat_q, pulses valid once.
  bit              busy = 1'b0;
  bit              core_stall = 1'b0;
  int              cdown = 0;
  logic [XLEN-1:0] cg = '0;
  logic [XLEN-1:0] ld_a = '0;
  logic [XLEN-1:0] ld_b = '0;
  int              ld_count = 0;

  assign core_ready_i = !busy && !core_stall;

  always @(negedge clk_i) begin
    core_valid_i = 1'b0;
    if (busy) begin
      cdown--;
      if (cdown == 0) begin
        core_valid_i = 1'b1;
        core_gcd_i   = cg;
        busy         = 1'b0;
      end
    end
    if (core_ld_o) begin
      ld_count++;
      ld_a  = core_a_o;
      ld_b  = core_b_o;
      cg    = ref_gcd(core_a_o, core_b_o);
      cdown = (lat_q.size() > 0) ? lat_q.pop_front() : 3;
      busy  = 1'b1;
    end
  end

  // Result monitor: every accepted result must match the head of the expected stream.
  always @(negedge clk_i) begin
    if (!rst_i && res_valid_o && res_ready_i) begin
      if (exp_g.size() == 0) begin
        check("extra_result", exp_g.size(), 1);
      end else begin
        check("res_gcd", res_gcd_o, exp_g[0]);
        check("res_cycles", res_cycles_o, exp_c[0]);
        check("res_bypass", res_bypass_o, exp_b[0]);
        void'(exp_g.pop_front());
        void'(exp_c.pop_front());
        void'(exp_b.pop_front());
      end
    end
  end

  // Offer one pair for one cycle; record it as expected only if it was accepted.
  task automatic push(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int lat, input bit wait_rdy);
    int n = 0;
    bit zero;
    if (wait_rdy) begin
      while (!op_ready_o && n < 300) begin
        res_ready_i = 1'b1;
        @(negedge clk_i);
        n++;
      end
      if (n >= 300) check("push_timeout", op_ready_o, 1);
    end
    op_valid_i = 1'b1;
    op_a_i     = a;
    op_b_i     = b;
    if (op_ready_o) begin
      zero = (a == '0) || (b == '0);
      exp_g.push_back(ref_gcd(a, b));
      exp_c.push_back(zero ? 0 : ((lat > LMAX) ? LMAX : lat));
      exp_b.push_back(zero);
      if (!zero) lat_q.push_back(lat);
    end
    @(negedge clk_i);
    op_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    res_ready_i = 1'b1;
    while (exp_g.size() != 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", exp_g.size(), 0);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    int base;
    int n;
    int seen;
    logic [XLEN-1:0] ra, rb;

    // Reset values
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    check("rst_op_ready", op_ready_o, 1);
    check("rst_core_ld", core_ld_o, 0);
    check("rst_core_a", core_a_o, 0);
    check("rst_core_b", core_b_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_gcd", res_gcd_o, 0);
    check("rst_res_cycles", res_cycles_o, 0);
    check("rst_res_bypass", res_bypass_o, 0);
    check("rst_count", count_o, 0);

    // Single job through the core
    push(32'd48, 32'd18, 5, 1'b1);
    drain();
    check("single_ld_count", ld_count, 1);
    check("single_core_a", ld_a, 48);
    check("single_core_b", ld_b, 18);

    // Zero bypass: core never loaded
    base = ld_count;
    push(32'd0, 32'd21, 0, 1'b1);
    push(32'd0, 32'd0, 0, 1'b1);
    push(32'd35, 32'd0, 0, 1'b1);
    drain();
    check("bypass_no_ld", ld_count, base);

    // Full FIFO with the core stalled
    core_stall = 1'b1;
    check("full_ready0", op_ready_o, 1);
    push(32'd12, 32'd8, 3, 1'b0);
    push(32'd9, 32'd6, 3, 1'b0);
    push(32'd100, 32'd75, 3, 1'b0);
    push(32'd14, 32'd21, 3, 1'b0);
    check("full_ready4", op_ready_o, 0);
    check("full_count4", count_o, 4);
    push(32'd5, 32'd10, 3, 1'b0);
    check("full_count5", count_o, 4);
    check("full_queued", exp_g.size(), 4);
    core_stall = 1'b0;
    drain();

    // Backpressure: result held for 10 cycles, no further issue
    res_ready_i = 1'b0;
    push(32'd27, 32'd9, 4, 1'b1);
    res_ready_i = 1'b0;
    push(32'd10, 32'd4, 2, 1'b1);
    res_ready_i = 1'b0;
    n = 0;
    while (!res_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    base = ld_count;
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", res_valid_o, 1);
      check("bp_gcd", res_gcd_o, exp_g[0]);
      check("bp_cycles", res_cycles_o, exp_c[0]);
      check("bp_no_ld", ld_count, base);
      @(negedge clk_i);
    end
    drain();
    check("bp_next_issued", ld_count, base + 1);

    // Latency counter saturation
    push(32'd7, 32'd3, 20, 1'b1);
    push(32'd20, 32'd15, 15, 1'b1);
    push(32'd9, 32'd3, 14, 1'b1);
    drain();

    // Random mix
    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 5000));
      res_ready_i = ($urandom_range(0, 3) != 0);
      push(ra, rb, $urandom_range(1, 24), 1'b1);
    end
    drain();

    // Reset mid-WAIT with three entries queued; stray core result afterwards
    push(32'd30, 32'd12, 30, 1'b1);
    push(32'd8, 32'd4, 3, 1'b1);
    push(32'd6, 32'd3, 3, 1'b1);
    push(32'd5, 32'd5, 3, 1'b1);
    check("mid_count", count_o, 3);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    exp_g.delete(); exp_c.delete(); exp_b.delete(); lat_q.delete();
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ready", op_ready_o, 1);
    check("mid_rst_valid", res_valid_o, 0);
    check("mid_rst_ld", core_ld_o, 0);
    base = ld_count;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid_o) seen++;
      @(negedge clk_i);
    end
    check("stray_ignored", seen, 0);
    check("stray_no_ld", ld_count, base);
    push(32'd16, 32'd24, 2, 1'b1);
    drain();
    check("post_rst_ld", ld_count, base + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gcd_feeder.md
Name: gcd_feeder

Overview:
Upstream stage for the gcd core. Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the core via its load/ready/valid interface and returns each result on a valid/ready result stream, tagged with the core's compute latency in cycles. Zero-operand pairs bypass the core, because the subtractive core does not terminate on zero.

Parameters:
XLEN, 32, operand and result width; must match the core's XLEN
DEPTH, 4, operand FIFO entries; power of two, at least 2
CNTW, 16, width of the latency counter and res_cycles_o

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  reset, synchronous, active-high
op_valid_i  in  1  operand pair valid
op_ready_o  out  1  FIFO can accept a pair (not full)
op_a_i  in  XLEN  operand A
op_b_i  in  XLEN  operand B
core_ld_o  out  1  load pulse to the core
core_a_o  out  XLEN  operand A to the core
core_b_o  out  XLEN  operand B to the core
core_ready_i  in  1  core idle and able to load
core_valid_i  in  1  core result valid
core_gcd_i  in  XLEN  core result
res_valid_o  out  1  result valid
res_ready_i  in  1  downstream accepts the result
res_gcd_o  out  XLEN  gcd result
res_cycles_o  out  CNTW  core latency for this result; 0 for a bypassed pair
res_bypass_o  out  1  result was produced by the zero bypass
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: applies when rst_i is high at a clock edge.
  - Outputs: op_ready_o=1; core_ld_o=0; core_a_o/core_b_o=0; res_valid_o=0; res_gcd_o=0; res_cycles_o=0; res_bypass_o=0; count_o=0.
  - State: FIFO pointers cleared; FSM to IDLE.
- Reset mid-operation discards all queued and in-flight jobs. The core is reset from the same reset net; a core result arriving after reset is ignored because the FSM is in IDLE.
- FIFO:
  - Push when op_valid_i && op_ready_o; pop on a dispatch (see FSM).
  - op_ready_o = (count_o != DEPTH). It is registered-state based with no combinational path from pop; a full FIFO stays not-ready even in a cycle that pops.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
  - Pushes while op_ready_o=0 are ignored.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE, FIFO empty: stay.
  - IDLE, head has head.a==0 or head.b==0: pop. Load res_gcd_o = head.a | head.b (so gcd(0,0)=0), res_cycles_o=0, res_bypass_o=1. Go to HOLD. core_ready_i is not required.
  - IDLE, both operands nonzero and core_ready_i=1: pop, latch head into core_a_o/core_b_o, clear counter. Go to ISSUE.
  - IDLE, both operands nonzero and core_ready_i=0: stay; the head is not popped.
  - ISSUE: core_ld_o=1 for exactly this cycle; core_a_o/core_b_o stable; counter=0. Go to WAIT.
  - WAIT: counter increments by 1 per cycle, saturating at 2^CNTW-1.
  - WAIT, core_valid_i=1: res_gcd_o <= core_gcd_i; res_cycles_o <= counter+1 (saturating); res_bypass_o <= 0. Go to HOLD.
  - HOLD: res_valid_o=1. All res_* outputs stay stable until res_ready_i=1 is sampled; then go to IDLE.
- core_valid_i is sampled only in WAIT and ignored elsewhere. The core must drop valid no later than the cycle after it samples core_ld_o.
- core_a_o/core_b_o hold their last issued values outside ISSUE/WAIT.
- res_cycles_o = number of cycles from the core_ld_o cycle (exclusive) to the cycle core_valid_i is sampled high (inclusive).
- Throughput: at most one job per IDLE→ISSUE→WAIT→HOLD round trip; a bypassed job takes 2 cycles (IDLE, HOLD) with res_ready_i held high.
- The feeder never issues a second core_ld_o before the previous result has left HOLD.

Test Plan:
- Reset: assert rst_i mid-WAIT with 3 entries queued → next cycle count_o=0, op_ready_o=1, res_valid_o=0, core_ld_o=0, FSM in IDLE; a later core_valid_i is ignored.
- Single job: push (48,18), core model returns 6 with valid 5 cycles after ld → exactly one core_ld_o pulse with core_a_o=48, core_b_o=18; then res_gcd_o=6, res_cycles_o=5, res_bypass_o=0.
- Full FIFO: push 5 pairs back-to-back with core_ready_i=0 and DEPTH=4 → op_ready_o drops after the 4th push, the 5th is ignored, count_o=4; results later return in push order.
- Zero bypass: push (0,21), (0,0), (35,0) → res_gcd_o 21, 0, 35 in order with res_cycles_o=0 and res_bypass_o=1; core_ld_o never asserts.
- Backpressure: hold res_ready_i=0 for 10 cycles while a result is in HOLD → res_* stable throughout, no new core_ld_o; the next job issues after res_ready_i=1 is sampled.
- Counter saturation: CNTW=4, core valid 20 cycles after ld → res_cycles_o=15.
